// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: turns PC addresses into ROM reads and queues {pc, instr} pairs for the decoder.
// Optional FETCH_PERF_EN adds saturating stall/drop counters.
module instruction_fetch_unit #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [15:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              flush
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_drop_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2;
  logic [1:0] state_q, state_d;
  logic req_q, req_d, live_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] fpc_q, fpc_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0][15:0] pcs_q, pcs_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic accept, push, pop;
  // count top bit set means count==DEPTH, i.e. full
  assign pc_ready    = live_q & (state_q == IDLE) & ~cnt_q[PW] & ~flush;
  assign instr_valid = (cnt_q != '0) & ~flush;
  assign instr       = data_q[rd_q];
  assign instr_pc    = pcs_q[rd_q];
  assign rom_req     = req_q;
  assign rom_addr    = addr_q;
  assign accept      = pc_valid & pc_ready;
  assign pop         = instr_valid & instr_ready;
  assign push        = (state_q == WAIT) & rom_ack & ~flush;
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    fpc_d   = fpc_q;
    data_d  = data_q;
    pcs_d   = pcs_q;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    if (accept) begin
      state_d = WAIT;
      req_d   = 1'b1;
      addr_d  = pc_in[ADDR_W-1:0];
      fpc_d   = pc_in;
    end
    if (state_q != IDLE && rom_ack) begin
      state_d = IDLE;
      req_d   = 1'b0;
    end else if (state_q == WAIT && flush) state_d = DROP;
    if (push) begin
      data_d[wr_q] = rom_data;
      pcs_d[wr_q]  = fpc_q;
    end
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      live_q  <= 1'b0;
      addr_q  <= '0;
      fpc_q   <= '0;
      data_q  <= '0;
      pcs_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      live_q  <= 1'b1;
      addr_q  <= addr_d;
      fpc_q   <= fpc_d;
      data_q  <= data_d;
      pcs_q   <= pcs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef FETCH_PERF_EN
  logic [15:0] stall_q, stall_d, drop_q, drop_d;
  logic stall_ev, drop_ev;
  assign stall_ev = instr_ready & ~instr_valid;
  assign drop_ev  = rom_ack & ((state_q == DROP) | ((state_q == WAIT) & flush));
  always_comb begin
    stall_d = (stall_ev && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    drop_d  = (drop_ev && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end
  assign perf_stall_cnt = stall_q;
  assign perf_drop_cnt  = drop_q;
`endif
endmodule
